// File: rtl/fadd_issue_ctrl.sv
// Round-robin issue of NREQ requesters onto one LAT-cycle FP adder; results LAT+1 cycles after grant via a credit-protected FIFO,
// so res_ready backpressure only withholds grants and never drops data. Optional counters under FADD_ISSUE_PERF_EN.
module fadd_issue_ctrl #(
    parameter int N     = 32,
    parameter int NREQ  = 2,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    input  logic [NREQ-1:0]         req_sub,
    input  logic [NREQ*3-1:0]       req_rm,
    input  logic [NREQ*TAGW-1:0]    req_tag,
    input  logic [2:0]              csr_frm,
    input  logic                    flush,
    output logic                    fu_valid,
    output logic [N-1:0]            fu_a,
    output logic [N-1:0]            fu_b,
    output logic [2:0]              fu_frm,
    input  logic [N-1:0]            fu_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_out,
    output logic [TAGW-1:0]         res_tag,
    output logic [$clog2(NREQ)-1:0] res_src,
    output logic                    res_illegal
`ifdef FADD_ISSUE_PERF_EN
    ,
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_stall,
    output logic [15:0]             perf_illegal
`endif
);
    localparam int SW = $clog2(NREQ);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [SW-1:0]   r_ptr;
    logic [LAT-1:0]  r_trk_v;
    logic [LAT-1:0]  r_trk_ill;
    logic [TAGW-1:0] r_trk_tag [LAT];
    logic [SW-1:0]   r_trk_src [LAT];

    logic [N-1:0]    r_mem_dat [DEPTH];
    logic [TAGW-1:0] r_mem_tag [DEPTH];
    logic [SW-1:0]   r_mem_src [DEPTH];
    logic            r_mem_ill [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;

    int              w_occ;
    logic            w_can_issue;
    logic            w_grant;
    logic            w_legal;
    logic            w_push;
    logic            w_pop;
    logic            w_res_valid;
    logic [SW-1:0]   w_gidx;
    logic [2:0]      w_sel_rm;
    logic [2:0]      w_rm;
    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;
    logic [TAGW-1:0] w_sel_tag;

    // Every op holds a credit from grant until it is popped, so the FIFO can always absorb the tracker.
    always_comb begin
        w_occ = int'(r_count);
        for (int k = 0; k < LAT; k++) w_occ = w_occ + int'(r_trk_v[k]);
    end

    assign w_can_issue = rst && !flush && (w_occ < DEPTH);

    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant && w_can_issue && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_grant = 1'b1;
                w_gidx  = SW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_gidx] = 1'b1;
    end

    assign w_sel_a   = req_a[w_gidx*N +: N];
    assign w_sel_b   = req_b[w_gidx*N +: N];
    assign w_sel_rm  = req_rm[w_gidx*3 +: 3];
    assign w_sel_tag = req_tag[w_gidx*TAGW +: TAGW];
    assign w_rm      = (w_sel_rm == 3'b111) ? csr_frm : w_sel_rm;
    assign w_legal   = (w_rm <= 3'd4);

    assign fu_valid = w_grant && w_legal;
    assign fu_a     = fu_valid ? w_sel_a : '0;
    assign fu_b     = fu_valid ? {w_sel_b[N-1] ^ req_sub[w_gidx], w_sel_b[N-2:0]} : '0;
    assign fu_frm   = fu_valid ? w_rm : 3'd0;

    assign w_push      = r_trk_v[LAT-1];
    assign w_res_valid = rst && (r_count != '0);
    assign w_pop       = w_res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_trk_v <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_trk_v <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_trk_v <= (r_trk_v << 1) | LAT'(w_grant);
            if (w_grant) r_ptr <= (w_gidx == SW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            if (w_push)  r_wr  <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)   r_rd  <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Payload needs no reset: only the valid bits and FIFO count qualify it.
    always_ff @(posedge clk) begin
        r_trk_ill[0] <= !w_legal;
        r_trk_tag[0] <= w_sel_tag;
        r_trk_src[0] <= w_gidx;
        for (int k = 1; k < LAT; k++) begin
            r_trk_ill[k] <= r_trk_ill[k-1];
            r_trk_tag[k] <= r_trk_tag[k-1];
            r_trk_src[k] <= r_trk_src[k-1];
        end
        if (w_push) begin
            r_mem_dat[r_wr] <= r_trk_ill[LAT-1] ? '0 : fu_out;
            r_mem_tag[r_wr] <= r_trk_tag[LAT-1];
            r_mem_src[r_wr] <= r_trk_src[LAT-1];
            r_mem_ill[r_wr] <= r_trk_ill[LAT-1];
        end
    end

    assign res_valid   = w_res_valid;
    assign res_out     = w_res_valid ? r_mem_dat[r_rd] : '0;
    assign res_tag     = w_res_valid ? r_mem_tag[r_rd] : '0;
    assign res_src     = w_res_valid ? r_mem_src[r_rd] : '0;
    assign res_illegal = w_res_valid && r_mem_ill[r_rd];

    always_ff @(posedge clk) begin
        if (rst && !flush) assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
    end

`ifdef FADD_ISSUE_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_illegal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_issued  <= '0;
            r_perf_stall   <= '0;
            r_perf_illegal <= '0;
        end else begin
            if (w_grant && (r_perf_issued != '1)) r_perf_issued <= r_perf_issued + 1'b1;
            if (w_grant && !w_legal && (r_perf_illegal != '1)) r_perf_illegal <= r_perf_illegal + 1'b1;
            if ((|req_valid) && !flush && !w_grant && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_issued  = r_perf_issued;
    assign perf_stall   = r_perf_stall;
    assign perf_illegal = r_perf_illegal;
`endif
endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Bench for fadd_issue_ctrl: directed steps then random traffic against a queue-based reference model.
module tb_fadd_issue_ctrl;
    localparam int N = 32, NREQ = 2, LAT = 2, DEPTH = 4, TAGW = 5;

    logic              clk, rst, flush, res_ready;
    logic [NREQ-1:0]   req_valid, req_ready, req_sub;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ*3-1:0] req_rm;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [2:0]        csr_frm, fu_frm;
    logic              fu_valid, res_valid, res_illegal;
    logic [N-1:0]      fu_a, fu_b, fu_out, res_out;
    logic [TAGW-1:0]   res_tag;
    logic [0:0]        res_src;
`ifdef FADD_ISSUE_PERF_EN
    logic [31:0]       perf_issued, perf_stall;
    logic [15:0]       perf_illegal;
`endif

    fadd_issue_ctrl #(.N(N), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_rm(req_rm), .req_tag(req_tag),
        .csr_frm(csr_frm), .flush(flush), .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b),
        .fu_frm(fu_frm), .fu_out(fu_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_tag(res_tag), .res_src(res_src), .res_illegal(res_illegal)
`ifdef FADD_ISSUE_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_illegal(perf_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int t; logic [31:0] val; logic [4:0] tag; int src; logic ill; } exp_t;
    typedef struct { int c; logic [31:0] v; } add_t;

    exp_t expq[$];
    add_t aq[$];
    int   errors = 0, checks = 0, cyc = 0, rr = 0, obs_grants = 0, g0;

    // Stand-in adder: any deterministic mix of the operands will do.
    function automatic logic [31:0] hsh(logic [31:0] a, logic [31:0] b);
        return (a + {b[15:0], b[31:16]}) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic sub, logic [2:0] rm, logic [4:0] tag);
        req_a[i*N +: N]       = a;
        req_b[i*N +: N]       = b;
        req_sub[i]            = sub;
        req_rm[i*3 +: 3]      = rm;
        req_tag[i*TAGW +: TAGW] = tag;
    endtask

    task automatic rnd_req();
        for (int i = 0; i < NREQ; i++)
            set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        csr_frm = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    endtask

    // One cycle: inputs already driven just after the edge; check at edge+2, feed the adder, advance.
    task automatic tick();
        bit exp_g, ex_rv;
        int exp_i;
        logic [NREQ-1:0] exp_rdy;
        logic [2:0] rm;
        logic [31:0] ea, eb;
        exp_t e;
        #1;
        exp_g = 0; exp_i = 0; rm = 3'd0; ea = '0; eb = '0;
        if (rst && !flush && expq.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (rr + k) % NREQ;
                if (!exp_g && req_valid[j]) begin exp_g = 1; exp_i = j; end
            end
        end
        exp_rdy = '0;
        if (exp_g) exp_rdy[exp_i] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (req_ready != '0) obs_grants++;
        if (exp_g) begin
            rm = req_rm[exp_i*3 +: 3];
            if (rm == 3'b111) rm = csr_frm;
            ea = req_a[exp_i*N +: N];
            eb = req_b[exp_i*N +: N];
            eb[31] = eb[31] ^ req_sub[exp_i];
            e.t = cyc + LAT + 1; e.tag = req_tag[exp_i*TAGW +: TAGW]; e.src = exp_i;
            e.ill = (rm > 3'd4);
            e.val = e.ill ? 32'd0 : hsh(ea, eb);
            expq.push_back(e);
            rr = (exp_i + 1) % NREQ;
            if (e.ill) begin rm = 3'd0; ea = '0; eb = '0; end
        end
        chk("fu_valid", 64'(fu_valid), 64'(exp_g && (ea != '0 || eb != '0 || rm != 0 || !e.ill)));
        chk("fu_a", 64'(fu_a), 64'(ea));
        chk("fu_b", 64'(fu_b), 64'(eb));
        chk("fu_frm", 64'(fu_frm), 64'(rm));
        ex_rv = rst && expq.size() > 0 && expq[0].t <= cyc;
        chk("res_valid", 64'(res_valid), 64'(ex_rv));
        if (ex_rv) begin
            chk("res_out", 64'(res_out), 64'(expq[0].val));
            chk("res_tag", 64'(res_tag), 64'(expq[0].tag));
            chk("res_src", 64'(res_src), 64'(expq[0].src));
            chk("res_illegal", 64'(res_illegal), 64'(expq[0].ill));
            if (res_ready && !flush) void'(expq.pop_front());
        end
        if (!rst) begin
            chk("rst_res_out", 64'(res_out), 64'd0);
            chk("rst_res_tag", 64'({res_tag, res_src, res_illegal}), 64'd0);
            expq.delete();
            rr = 0;
        end else if (flush) begin
            expq.delete();
        end
        if (aq.size() > 0 && aq[0].c == cyc - LAT) begin
            fu_out = aq[0].v;
            void'(aq.pop_front());
        end else begin
            fu_out = $urandom;
        end
        if (fu_valid) aq.push_back('{c: cyc, v: hsh(fu_a, fu_b)});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; res_ready = 1'b1; csr_frm = 3'd0; req_valid = '0;
        req_a = '0; req_b = '0; req_sub = '0; req_rm = '0; req_tag = '0; fu_out = '0;
        @(posedge clk);
        #1;
        rnd_req();
        req_valid = 2'b11;
        repeat (2) tick();
        rst = 1'b1; req_valid = '0; csr_frm = 3'd0;
        tick();

        // single add from requester 0, tag 3
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0, 3'b000, 5'd3);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        repeat (5) tick();

        // fsub with dynamic rounding from fcsr.frm
        csr_frm = 3'b001;
        set_req(1, 32'h3F800000, 32'h40000000, 1'b1, 3'b111, 5'd9);
        req_valid = 2'b10;
        #1;
        chk("fu_b_sub", 64'(fu_b), 64'h0000_0000_C000_0000);
        chk("fu_frm_dyn", 64'(fu_frm), 64'd1);
        tick();
        req_valid = '0;
        repeat (5) tick();

        // illegal static rm, then illegal dynamic frm
        set_req(0, 32'h12345678, 32'h40000000, 1'b0, 3'b101, 5'd7);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        repeat (5) tick();
        csr_frm = 3'b110;
        set_req(0, 32'h12345678, 32'h40000000, 1'b0, 3'b111, 5'd12);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        repeat (5) tick();

        // both streaming with writeback always ready
        req_valid = 2'b11;
        repeat (12) begin rnd_req(); tick(); end
        req_valid = '0;
        repeat (6) tick();

        // writeback stalled: only DEPTH grants fit
        res_ready = 1'b0;
        g0 = obs_grants;
        req_valid = 2'b11;
        repeat (8) begin rnd_req(); tick(); end
        chk("stall_grants", 64'(obs_grants - g0), 64'(DEPTH));
        res_ready = 1'b1;
        repeat (10) begin rnd_req(); tick(); end
        req_valid = '0;
        repeat (6) tick();

        // flush with two in flight and one buffered
        csr_frm = 3'd0;
        res_ready = 1'b0;
        set_req(0, 32'h11111111, 32'h22222222, 1'b0, 3'b000, 5'd1);
        req_valid = 2'b01;
        repeat (3) tick();
        req_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("res_valid_post_flush", 64'(res_valid), 64'd0);
        res_ready = 1'b1;
        set_req(1, 32'h33333333, 32'h44444444, 1'b0, 3'b010, 5'd21);
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        repeat (5) tick();

        // random traffic with occasional flush and reset
        repeat (600) begin
            rnd_req();
            req_valid = 2'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst = 1'b1; flush = 1'b0; res_ready = 1'b1; req_valid = '0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
